// File: rtl/noc_pkg.sv
// Shared NoC definitions: mesh directions, arbitration modes, inject-mux state.
package noc_pkg;

   localparam int unsigned DIR_NUM   = 5;
   localparam int unsigned DIR_LOCAL = 0;
   localparam int unsigned DIR_NORTH = 1;
   localparam int unsigned DIR_EAST  = 2;
   localparam int unsigned DIR_SOUTH = 3;
   localparam int unsigned DIR_WEST  = 4;

   localparam logic [DIR_NUM-1:0] DIR_LOCAL_OH = 5'b00001;
   localparam logic [DIR_NUM-1:0] DIR_NORTH_OH = 5'b00010;
   localparam logic [DIR_NUM-1:0] DIR_EAST_OH  = 5'b00100;
   localparam logic [DIR_NUM-1:0] DIR_SOUTH_OH = 5'b01000;
   localparam logic [DIR_NUM-1:0] DIR_WEST_OH  = 5'b10000;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } mux_state_e;

   // Index width that stays at least one bit for single-entry vectors.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Request arbiter: round-robin search from ptr, or fixed priority (lowest index) when ARB_MODE=ARB_FIXED.
module noc_rr_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned N        = 2,
   parameter int unsigned ARB_MODE = ARB_RR
) (
   input  logic [N-1:0]               req,
   input  logic [idx_width(N)-1:0]    ptr,
   output logic [N-1:0]               grant,
   output logic [idx_width(N)-1:0]    grant_idx,
   output logic                       grant_valid
);

   localparam int unsigned IDX_W = idx_width(N);

   int unsigned start;
   int unsigned k;

   // First requester found walking upward from the start index, wrapping at N.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      start       = (ARB_MODE == ARB_FIXED) ? 0 : 32'(ptr);
      k           = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (start + i) % N;
         if (!grant_valid && req[IDX_W'(k)]) begin
            grant_valid        = 1'b1;
            grant_idx          = IDX_W'(k);
            grant[IDX_W'(k)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_vc_inject_mux.sv
// Tile-to-router local injection mux: packet-granular VC arbitration into a one-flit output register.
// Optional statistics counters enabled by defining NOC_VC_MUX_STATS_EN.
module noc_vc_inject_mux
   import noc_pkg::*;
#(
   parameter int unsigned FLIT_WIDTH = 32,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned ARB_MODE   = ARB_RR,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]   in_flit,
   input  logic [CHANNELS-1:0]                   in_last,
   input  logic [CHANNELS-1:0]                   in_valid,
   output logic [CHANNELS-1:0]                   in_ready,
   output logic [FLIT_WIDTH-1:0]                 out_flit,
   output logic                                  out_last,
   output logic [CHANNELS-1:0]                   out_valid,
   input  logic [CHANNELS-1:0]                   out_ready
`ifdef NOC_VC_MUX_STATS_EN
   ,
   output logic [CHANNELS-1:0][CNT_WIDTH-1:0]    stat_pkt_cnt,
   output logic [CNT_WIDTH-1:0]                  stat_stall_cnt
`endif
);

   localparam int unsigned IDX_W = idx_width(CHANNELS);

   if (CHANNELS < 1 || CHANNELS > 8 || CNT_WIDTH < 1) begin : g_param_check
      $error("noc_vc_inject_mux: illegal CHANNELS or CNT_WIDTH");
   end

   mux_state_e                state_q, state_d;
   logic [IDX_W-1:0]          lock_vc_q, lock_vc_d;
   logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [FLIT_WIDTH-1:0]     out_flit_q, out_flit_d;
   logic                      out_last_q, out_last_d;
   logic [CHANNELS-1:0]       out_valid_q, out_valid_d;

   logic [CHANNELS-1:0]       arb_grant;
   logic [IDX_W-1:0]          arb_idx;
   logic                      arb_valid;
   logic [IDX_W-1:0]          grant_vc;
   logic [CHANNELS-1:0]       grant_oh;
   logic                      grant_ok;
   logic                      drain;
   logic                      can_load;
   logic                      accept;
   logic                      acc_last;

   noc_rr_arbiter #(
      .N        (CHANNELS),
      .ARB_MODE (ARB_MODE)
   ) u_arb (
      .req         (in_valid),
      .ptr         (rr_ptr_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lock_vc_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_vc_q <= lock_vc_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // Next-state: lock on a non-last accept, release and advance pointer on a last accept
   always_comb begin
      state_d   = state_q;
      lock_vc_d = lock_vc_q;
      rr_ptr_d  = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !acc_last) begin
               state_d   = ST_LOCKED;
               lock_vc_d = grant_vc;
            end
         end
         ST_LOCKED: begin
            if (accept && acc_last) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept && acc_last) begin
         rr_ptr_d = (grant_vc == IDX_W'(CHANNELS - 1)) ? '0 : grant_vc + IDX_W'(1);
      end
   end

   // Outputs: grant selection and the combinational in_ready path from out_ready
   always_comb begin
      grant_vc = (state_q == ST_LOCKED) ? lock_vc_q : arb_idx;
      grant_oh = (state_q == ST_LOCKED) ? (CHANNELS'(1) << lock_vc_q) : arb_grant;
      grant_ok = (state_q == ST_LOCKED) || arb_valid;
      drain    = |(out_valid_q & out_ready);
      can_load = (out_valid_q == '0) || drain;
      in_ready = grant_oh & {CHANNELS{can_load & grant_ok & rst_n}};
      accept   = |(in_valid & in_ready);
      acc_last = in_last[grant_vc];
   end

   // Holding stage: load on accept (replacing a draining flit), empty on drain only
   always_comb begin
      out_flit_d  = out_flit_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         out_flit_d  = in_flit[grant_vc];
         out_last_d  = acc_last;
         out_valid_d = grant_oh;
      end else if (drain) begin
         out_valid_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_flit_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= '0;
      end else begin
         out_flit_q  <= out_flit_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_flit  = out_flit_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;

`ifdef NOC_VC_MUX_STATS_EN
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [CNT_WIDTH-1:0]               stall_cnt_q, stall_cnt_d;

   // Saturating counters: packets leaving per VC, cycles held without drain
   always_comb begin
      pkt_cnt_d   = pkt_cnt_q;
      stall_cnt_d = stall_cnt_q;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (drain && out_valid_q[IDX_W'(c)] && out_last_q && (pkt_cnt_q[IDX_W'(c)] != '1)) begin
            pkt_cnt_d[IDX_W'(c)] = pkt_cnt_q[IDX_W'(c)] + CNT_WIDTH'(1);
         end
      end
      if ((out_valid_q != '0) && !drain && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         pkt_cnt_q   <= pkt_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stat_pkt_cnt   = pkt_cnt_q;
   assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_noc_vc_inject_mux.sv
// Directed self-checking bench for noc_vc_inject_mux: 2-VC round-robin instance and 4-VC fixed-priority instance.
module tb_noc_vc_inject_mux;

   localparam int unsigned FW = 16;

   logic clk;
   logic rst_n;

   logic [1:0][FW-1:0] in_flit;
   logic [1:0]         in_last;
   logic [1:0]         in_valid;
   logic [1:0]         in_ready;
   logic [FW-1:0]      out_flit;
   logic               out_last;
   logic [1:0]         out_valid;
   logic [1:0]         out_ready;

   logic [3:0][FW-1:0] f_in_flit;
   logic [3:0]         f_in_last;
   logic [3:0]         f_in_valid;
   logic [3:0]         f_in_ready;
   logic [FW-1:0]      f_out_flit;
   logic               f_out_last;
   logic [3:0]         f_out_valid;
   logic [3:0]         f_out_ready;

`ifdef NOC_VC_MUX_STATS_EN
   logic [1:0][15:0]   stat_pkt_cnt;
   logic [15:0]        stat_stall_cnt;
   logic [3:0][15:0]   f_stat_pkt_cnt;
   logic [15:0]        f_stat_stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   noc_vc_inject_mux #(
      .FLIT_WIDTH (FW),
      .CHANNELS   (2),
      .ARB_MODE   (0),
      .CNT_WIDTH  (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_flit   (in_flit),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef NOC_VC_MUX_STATS_EN
      ,
      .stat_pkt_cnt   (stat_pkt_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   noc_vc_inject_mux #(
      .FLIT_WIDTH (FW),
      .CHANNELS   (4),
      .ARB_MODE   (1),
      .CNT_WIDTH  (16)
   ) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_flit   (f_in_flit),
      .in_last   (f_in_last),
      .in_valid  (f_in_valid),
      .in_ready  (f_in_ready),
      .out_flit  (f_out_flit),
      .out_last  (f_out_last),
      .out_valid (f_out_valid),
      .out_ready (f_out_ready)
`ifdef NOC_VC_MUX_STATS_EN
      ,
      .stat_pkt_cnt   (f_stat_pkt_cnt),
      .stat_stall_cnt (f_stat_stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_flit     = '0;
      in_last     = '0;
      in_valid    = '0;
      out_ready   = 2'b11;
      f_in_flit   = '0;
      f_in_last   = '0;
      f_in_valid  = '0;
      f_out_ready = 4'b1111;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      clear_inputs();
      in_valid = 2'b11;
      f_in_valid = 4'b1111;
      tick();
      tick();
      checks++;
      if (out_valid !== 2'b00) begin failures++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
      checks++;
      if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++;
      if (out_flit !== 16'h0000) begin failures++; $display("FAIL reset_out_flit got=%h exp=0000", out_flit); end
      checks++;
      if (in_ready !== 2'b00) begin failures++; $display("FAIL reset_in_ready got=%b exp=00", in_ready); end
      checks++;
      if (f_in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready4 got=%b exp=0000", f_in_ready); end
      rst_n = 1'b1;
      clear_inputs();
   endtask

   task automatic test_single_packet();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid   = 2'b01;
         in_flit[0] = 16'hA000 + 16'(i);
         in_last[0] = (i == 2);
         #1;
         checks++;
         if (in_ready !== 2'b01) begin failures++; $display("FAIL single_in_ready[%0d] got=%b exp=01", i, in_ready); end
         tick();
         checks++;
         if (out_valid !== 2'b01 || out_flit !== 16'hA000 + 16'(i) || out_last !== (i == 2)) begin
            failures++;
            $display("FAIL single_out[%0d] got=%b/%h/%b exp=01/%h/%b", i, out_valid, out_flit, out_last, 16'hA000 + 16'(i), (i == 2));
         end
      end
      in_valid = 2'b00;
      #1;
      checks++;
      if (in_ready !== 2'b00) begin failures++; $display("FAIL single_idle_ready got=%b exp=00", in_ready); end
      tick();
      checks++;
      if (out_valid !== 2'b00) begin failures++; $display("FAIL single_drained got=%b exp=00", out_valid); end
   endtask

   task automatic test_rr_two_vc();
      logic [1:0]    exp_rdy  [4];
      logic [FW-1:0] exp_flit [4];
      logic          exp_last [4];
      int ia, ib;
      logic [1:0] acc;
      exp_rdy  = '{2'b01, 2'b01, 2'b10, 2'b10};
      exp_flit = '{16'hB000, 16'hB001, 16'hC000, 16'hC001};
      exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
      apply_reset();
      ia = 0;
      ib = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         in_valid[0] = (ia < 2);
         in_flit[0]  = 16'hB000 + 16'(ia);
         in_last[0]  = (ia == 1);
         in_valid[1] = (ib < 2);
         in_flit[1]  = 16'hC000 + 16'(ib);
         in_last[1]  = (ib == 1);
         #1;
         checks++;
         if (in_ready !== exp_rdy[cyc]) begin failures++; $display("FAIL rr_in_ready[%0d] got=%b exp=%b", cyc, in_ready, exp_rdy[cyc]); end
         acc = in_valid & in_ready;
         tick();
         if (acc[0]) ia++;
         if (acc[1]) ib++;
         checks++;
         if (out_valid !== exp_rdy[cyc] || out_flit !== exp_flit[cyc] || out_last !== exp_last[cyc]) begin
            failures++;
            $display("FAIL rr_out[%0d] got=%b/%h/%b exp=%b/%h/%b", cyc, out_valid, out_flit, out_last, exp_rdy[cyc], exp_flit[cyc], exp_last[cyc]);
         end
      end
      // Pointer has wrapped back to VC0 after VC1's last flit
      in_valid = 2'b11;
      in_last  = 2'b11;
      #1;
      checks++;
      if (in_ready !== 2'b01) begin failures++; $display("FAIL rr_ptr_wrap got=%b exp=01", in_ready); end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [1:0]    exp_oh   [4];
      logic [FW-1:0] exp_flit [4];
      int n0, n1;
      logic [1:0] acc;
      exp_oh   = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_flit = '{16'h1000, 16'h2000, 16'h1001, 16'h2001};
      apply_reset();
      n0 = 0;
      n1 = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         in_valid   = 2'b11;
         in_last    = 2'b11;
         in_flit[0] = 16'h1000 + 16'(n0);
         in_flit[1] = 16'h2000 + 16'(n1);
         #1;
         checks++;
         if (in_ready !== exp_oh[cyc]) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", cyc, in_ready, exp_oh[cyc]); end
         acc = in_valid & in_ready;
         tick();
         if (acc[0]) n0++;
         if (acc[1]) n1++;
         checks++;
         if (out_valid !== exp_oh[cyc] || out_flit !== exp_flit[cyc] || out_last !== 1'b1) begin
            failures++;
            $display("FAIL b2b_out[%0d] got=%b/%h/%b exp=%b/%h/1", cyc, out_valid, out_flit, out_last, exp_oh[cyc], exp_flit[cyc]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      apply_reset();
      out_ready   = 2'b01;
      in_valid    = 2'b10;
      in_last     = 2'b10;
      in_flit[1]  = 16'h3333;
      #1;
      checks++;
      if (in_ready !== 2'b10) begin failures++; $display("FAIL bp_first_ready got=%b exp=10", in_ready); end
      tick();
      in_flit[1] = 16'h4444;
      for (int cyc = 0; cyc < 5; cyc++) begin
         #1;
         checks++;
         if (in_ready !== 2'b00) begin failures++; $display("FAIL bp_stall_ready[%0d] got=%b exp=00", cyc, in_ready); end
         checks++;
         if (out_valid !== 2'b10 || out_flit !== 16'h3333 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=10/3333/1", cyc, out_valid, out_flit, out_last);
         end
         tick();
      end
      out_ready = 2'b11;
      #1;
      checks++;
      if (in_ready !== 2'b10) begin failures++; $display("FAIL bp_release_ready got=%b exp=10", in_ready); end
      tick();
      in_valid = 2'b00;
      checks++;
      if (out_valid !== 2'b10 || out_flit !== 16'h4444) begin
         failures++;
         $display("FAIL bp_replace got=%b/%h exp=10/4444", out_valid, out_flit);
      end
      tick();
      checks++;
      if (out_valid !== 2'b00) begin failures++; $display("FAIL bp_empty got=%b exp=00", out_valid); end
      clear_inputs();
   endtask

   task automatic test_source_gap();
      apply_reset();
      in_valid   = 2'b11;
      in_flit[0] = 16'h5000;
      in_last[0] = 1'b0;
      in_flit[1] = 16'h6000;
      in_last[1] = 1'b1;
      #1;
      checks++;
      if (in_ready !== 2'b01) begin failures++; $display("FAIL gap_first_ready got=%b exp=01", in_ready); end
      tick();
      in_valid[0] = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         #1;
         checks++;
         if (in_ready !== 2'b01) begin failures++; $display("FAIL gap_locked_ready[%0d] got=%b exp=01", cyc, in_ready); end
         tick();
         checks++;
         if (out_valid !== 2'b00) begin failures++; $display("FAIL gap_no_interleave[%0d] got=%b exp=00", cyc, out_valid); end
      end
      for (int i = 1; i < 3; i++) begin
         in_valid[0] = 1'b1;
         in_flit[0]  = 16'h5000 + 16'(i);
         in_last[0]  = (i == 2);
         #1;
         checks++;
         if (in_ready !== 2'b01) begin failures++; $display("FAIL gap_resume_ready[%0d] got=%b exp=01", i, in_ready); end
         tick();
         checks++;
         if (out_valid !== 2'b01 || out_flit !== 16'h5000 + 16'(i) || out_last !== (i == 2)) begin
            failures++;
            $display("FAIL gap_resume_out[%0d] got=%b/%h/%b exp=01/%h/%b", i, out_valid, out_flit, out_last, 16'h5000 + 16'(i), (i == 2));
         end
      end
      in_valid[0] = 1'b0;
      #1;
      checks++;
      if (in_ready !== 2'b10) begin failures++; $display("FAIL gap_vc1_ready got=%b exp=10", in_ready); end
      tick();
      checks++;
      if (out_valid !== 2'b10 || out_flit !== 16'h6000 || out_last !== 1'b1) begin
         failures++;
         $display("FAIL gap_vc1_out got=%b/%h/%b exp=10/6000/1", out_valid, out_flit, out_last);
      end
      clear_inputs();
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      for (int c = 0; c < 4; c++) f_in_flit[c] = 16'hF000 + 16'(c);
      f_in_last  = 4'b1111;
      f_in_valid = 4'b1111;
      for (int cyc = 0; cyc < 3; cyc++) begin
         #1;
         checks++;
         if (f_in_ready !== 4'b0001) begin failures++; $display("FAIL fixed_ready[%0d] got=%b exp=0001", cyc, f_in_ready); end
         tick();
         checks++;
         if (f_out_valid !== 4'b0001 || f_out_flit !== 16'hF000 || f_out_last !== 1'b1) begin
            failures++;
            $display("FAIL fixed_out[%0d] got=%b/%h/%b exp=0001/f000/1", cyc, f_out_valid, f_out_flit, f_out_last);
         end
      end
      f_in_valid = 4'b1110;
      #1;
      checks++;
      if (f_in_ready !== 4'b0010) begin failures++; $display("FAIL fixed_next_ready got=%b exp=0010", f_in_ready); end
      tick();
      checks++;
      if (f_out_valid !== 4'b0010 || f_out_flit !== 16'hF001) begin
         failures++;
         $display("FAIL fixed_next_out got=%b/%h exp=0010/f001", f_out_valid, f_out_flit);
      end
      clear_inputs();
   endtask

   task automatic test_reset_locked();
      apply_reset();
      out_ready  = 2'b01;
      in_valid   = 2'b10;
      in_flit[1] = 16'h7000;
      in_last[1] = 1'b0;
      tick();
      checks++;
      if (out_valid !== 2'b10 || out_flit !== 16'h7000) begin
         failures++;
         $display("FAIL rstlk_held got=%b/%h exp=10/7000", out_valid, out_flit);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 2'b00) begin failures++; $display("FAIL rstlk_ready_low got=%b exp=00", in_ready); end
      tick();
      checks++;
      if (out_valid !== 2'b00 || out_flit !== 16'h0000 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL rstlk_cleared got=%b/%h/%b exp=00/0000/0", out_valid, out_flit, out_last);
      end
`ifdef NOC_VC_MUX_STATS_EN
      checks++;
      if (stat_pkt_cnt !== '0 || stat_stall_cnt !== '0) begin
         failures++;
         $display("FAIL rstlk_stats got=%h/%h exp=0/0", stat_pkt_cnt, stat_stall_cnt);
      end
`endif
      rst_n     = 1'b1;
      out_ready = 2'b11;
      in_valid  = 2'b11;
      in_last   = 2'b11;
      #1;
      checks++;
      if (in_ready !== 2'b01) begin failures++; $display("FAIL rstlk_unlocked got=%b exp=01", in_ready); end
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_single_packet();
      test_rr_two_vc();
      test_back_to_back();
      test_backpressure();
      test_source_gap();
      test_fixed_priority();
      test_reset_locked();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
